// File: rtl/fb_arb_pkg.sv
// Shared constants, state encoding and port helpers for the frame-buffer burst arbiter.
package fb_arb_pkg;
  localparam int NUM_PORTS  = 4;
  localparam int BASE_W     = 3;
  localparam int NUM_FRAMES = 5;

  localparam logic [1:0] WR_PORT = 2'd0;
  localparam logic [1:0] RD0     = 2'd1;
  localparam logic [1:0] RD1     = 2'd2;
  localparam logic [1:0] RD2     = 2'd3;

  typedef enum logic [1:0] {IDLE, CHECK, CMD, WAIT} arb_state_t;

  // Port 0 is always present; read ports above rdport are masked off.
  function automatic logic [NUM_PORTS-1:0] port_mask(input int rdport);
    logic [NUM_PORTS-1:0] m;
    for (int n = 0; n < NUM_PORTS; n++) begin
      m[n] = (n == 0) || (n <= rdport);
    end
    return m;
  endfunction

  function automatic logic [NUM_PORTS-1:0] port_bit(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin pick with optional fixed priority for port 0.
module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  input  logic       prio0,
  output logic [1:0] win,
  output logic       any
);
  always_comb begin
    win = 2'd0;
    // Scan from the far end back to ptr so the last hit is the first port at or after ptr.
    for (int i = 3; i >= 0; i--) begin
      logic [1:0] idx;
      idx = ptr + 2'(i);
      if (eligible[idx]) win = idx;
    end
    if (prio0 && eligible[0]) win = 2'd0;
    any = |eligible;
  end
endmodule

// File: rtl/fb_burst_arbiter.sv
// Arbitrates one memory command port between the frame-buffer writer (port 0) and up to three readers.
module fb_burst_arbiter
  import fb_arb_pkg::*;
#(
  parameter int RDPORT  = 3,
  parameter int OFF_W   = 20,
  parameter int LEN_W   = 8,
  parameter int WR_PRIO = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*BASE_W-1:0] base,
  input  logic [NUM_PORTS*OFF_W-1:0]  offset,
  input  logic [NUM_PORTS*LEN_W-1:0]  len,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [NUM_PORTS-1:0]        err,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic                        cmd_wr,
  output logic [BASE_W+OFF_W-1:0]     cmd_addr,
  output logic [LEN_W-1:0]            cmd_len,
  output logic [1:0]                  cmd_port,
  input  logic                        mem_done,
  output logic                        busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t                 r_state, w_state_nxt;
  logic [1:0]                 r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [NUM_PORTS-1:0]       r_ack, r_err, w_ack_nxt, w_err_nxt;
  logic                       r_cmd_valid, w_valid_nxt;
  logic                       r_cmd_wr;
  logic [BASE_W+OFF_W-1:0]    r_cmd_addr;
  logic [LEN_W-1:0]           r_cmd_len;
  logic [1:0]                 r_cmd_port;
  logic                       w_grant;
  logic [NUM_PORTS-1:0]       w_elig;
  logic [1:0]                 w_win;
  logic                       w_any;
  logic                       w_prio0;
  logic                       w_base_bad;

  assign w_elig     = req & port_mask(RDPORT);
  assign w_prio0    = (WR_PRIO != 0);
  // The granted base is held in the top bits of cmd_addr, so CHECK validates it there.
  assign w_base_bad = r_cmd_addr[BASE_W+OFF_W-1 -: BASE_W] >= BASE_W'(NUM_FRAMES);

  rr_pick4 u_pick (
    .eligible (w_elig),
    .ptr      (r_ptr),
    .prio0    (w_prio0),
    .win      (w_win),
    .any      (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = '0;
    w_err_nxt   = '0;
    w_valid_nxt = r_cmd_valid;
    w_grant     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = CHECK;
          if (w_prio0 && (w_win == WR_PORT)) w_ptr_nxt = WR_PORT + 2'd1;
        end
      end
      CHECK: begin
        if (w_base_bad) begin
          w_err_nxt   = port_bit(r_cmd_port);
          w_ptr_nxt   = r_cmd_port + 2'd1;
          w_state_nxt = IDLE;
        end else if (r_cmd_len == '0) begin
          w_ack_nxt   = port_bit(r_cmd_port);
          w_ptr_nxt   = r_cmd_port + 2'd1;
          w_state_nxt = IDLE;
        end else begin
          w_valid_nxt = 1'b1;
          w_state_nxt = CMD;
        end
      end
      CMD: begin
        if (cmd_ready) begin
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_done) begin
          w_ack_nxt   = port_bit(r_cmd_port);
          w_ptr_nxt   = r_cmd_port + 2'd1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_err_nxt   = port_bit(r_cmd_port);
          w_ptr_nxt   = r_cmd_port + 2'd1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_err       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_wr    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_len   <= '0;
      r_cmd_port  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_cmd_valid <= w_valid_nxt;
      if (w_grant) begin
        r_cmd_port <= w_win;
        r_cmd_wr   <= (w_win == WR_PORT);
        r_cmd_addr <= {base[BASE_W*w_win +: BASE_W], offset[OFF_W*w_win +: OFF_W]};
        r_cmd_len  <= len[LEN_W*w_win +: LEN_W];
      end
    end
  end

  assign ack       = r_ack;
  assign err       = r_err;
  assign cmd_valid = r_cmd_valid;
  assign cmd_wr    = r_cmd_wr;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_len   = r_cmd_len;
  assign cmd_port  = r_cmd_port;
  assign busy      = (r_state != IDLE);
endmodule
